// File: rtl/inst_queue_if.sv
// Fetch/decoder handshake bundle for the instruction queue.
// master = fetch/decoder/ROB side, slave = the queue itself.
interface inst_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              enq_valid;
    logic [31:0]       enq_pc;
    logic [31:0]       enq_inst;
    logic              enq_rdy;
    logic              deq_valid;
    logic [31:0]       deq_pc;
    logic [31:0]       deq_inst;
    logic [63:0]       deq_order;
    logic              deq_rdy;
    logic              flush;
    logic [63:0]       flush_order;
    logic [CNT_W-1:0]  count;

    modport master (
        output enq_valid, enq_pc, enq_inst, deq_rdy, flush, flush_order,
        input  enq_rdy, deq_valid, deq_pc, deq_inst, deq_order, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_inst, deq_rdy, flush, flush_order,
        output enq_rdy, deq_valid, deq_pc, deq_inst, deq_order, count
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst}
// with program-order tagging on dequeue and single-cycle flush.
module inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    inst_queue_if.slave q
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]   head;
    logic [IDX_W:0]   tail;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [63:0]      order;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

    // Flush gates both handshakes so nothing moves in the flush cycle.
    // A full queue refuses enqueue even if a dequeue happens the same cycle.
    assign q.enq_rdy   = !full && !q.flush;
    assign q.deq_valid = !empty && !q.flush;
    assign enq_fire    = q.enq_valid && q.enq_rdy;
    assign deq_fire    = q.deq_valid && q.deq_rdy;

    // Head entry is read straight from storage; a fresh enqueue is never bypassed.
    assign q.deq_pc    = pc_mem[head_idx];
    assign q.deq_inst  = inst_mem[head_idx];
    assign q.deq_order = order;
    assign q.count     = tail - head;

    // Entry storage: cleared on reset so the outputs are defined before any enqueue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (enq_fire) begin
            pc_mem[tail_idx]   <= q.enq_pc;
            inst_mem[tail_idx] <= q.enq_inst;
        end
    end

    // Pointer and order-counter update; flush overrides any traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            order <= '0;
        end else if (q.flush) begin
            head  <= '0;
            tail  <= '0;
            order <= q.flush_order;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (deq_fire) begin
                head  <= head + PTR_ONE;
                order <= order + 64'd1;
            end
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a random
// back-pressure run, all checked against a queue-based reference model.
module tb_inst_queue;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_queue_if #(.DEPTH(DEPTH)) qi ();
    inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(qi.slave));

    logic [63:0] sb[$];
    logic [63:0] m_order;
    int          total = 0;
    int          bad   = 0;
    bit          last_acc;

    // Advance one cycle: decide handshakes from the model, apply them at the edge.
    task automatic tick();
        bit e_ok;
        bit d_ok;
        e_ok = (sb.size() < DEPTH) && !qi.flush;
        d_ok = (sb.size() != 0) && !qi.flush;
        last_acc = e_ok && qi.enq_valid;
        @(posedge clk);
        if (qi.flush) begin
            sb.delete();
            m_order = qi.flush_order;
        end else begin
            if (d_ok && qi.deq_rdy) begin
                void'(sb.pop_front());
                m_order = m_order + 64'd1;
            end
            if (e_ok && qi.enq_valid) sb.push_back({qi.enq_pc, qi.enq_inst});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        qi.enq_valid = 0; qi.enq_pc = '0; qi.enq_inst = '0;
        qi.deq_rdy = 0; qi.flush = 0; qi.flush_order = '0;
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (qi.count !== '0) begin bad++; $display("FAIL reset_hold_count got=%0d exp=0", qi.count); end
        rst = 1;
        sb.delete(); m_order = '0; last_acc = 0;
        #1;
        total++; if (qi.enq_rdy !== 1'b1) begin bad++; $display("FAIL reset_enq_rdy got=%b exp=1", qi.enq_rdy); end
        total++; if (qi.deq_valid !== 1'b0) begin bad++; $display("FAIL reset_deq_valid got=%b exp=0", qi.deq_valid); end
        total++; if (qi.deq_pc !== 32'h0 || qi.deq_inst !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", qi.deq_pc, qi.deq_inst); end
        total++; if (qi.deq_order !== 64'h0) begin bad++; $display("FAIL reset_order got=%h exp=0", qi.deq_order); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            qi.enq_valid = 1; qi.enq_pc = 32'(32'h1000 + 4 * i); qi.enq_inst = 32'(32'hA000_0000 + i);
            qi.deq_rdy = 0;
            #1;
            total++; if (qi.enq_rdy !== 1'b1) begin bad++; $display("FAIL fill_rdy i=%0d got=%b exp=1", i, qi.enq_rdy); end
            total++; if (qi.count !== CNT_W'(i)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", qi.count, i); end
            tick();
        end
        qi.enq_valid = 0;
        #1;
        total++; if (qi.count !== CNT_W'(DEPTH)) begin bad++; $display("FAIL full_count got=%0d exp=%0d", qi.count, DEPTH); end
        total++; if (qi.enq_rdy !== 1'b0) begin bad++; $display("FAIL full_enq_rdy got=%b exp=0", qi.enq_rdy); end
        total++; if (qi.deq_valid !== 1'b1) begin bad++; $display("FAIL full_deq_valid got=%b exp=1", qi.deq_valid); end
        total++; if (qi.deq_pc !== 32'h1000 || qi.deq_order !== 64'h0) begin bad++; $display("FAIL full_head got=%h/%0d exp=1000/0", qi.deq_pc, qi.deq_order); end
    endtask

    task automatic test_drain_wrap();
        logic [31:0] npc;
        npc = 32'h1020;
        for (int k = 0; k < 3 * DEPTH + 2; k++) begin
            qi.enq_valid = 1; qi.enq_pc = npc; qi.enq_inst = ~npc; qi.deq_rdy = 1;
            #1;
            if (k == 0) begin
                total++; if (qi.enq_rdy !== 1'b0) begin bad++; $display("FAIL full_no_reuse got=%b exp=0", qi.enq_rdy); end
            end else begin
                total++; if (!(qi.count === CNT_W'(DEPTH - 1) || qi.count === CNT_W'(DEPTH))) begin bad++; $display("FAIL wrap_count got=%0d exp=7..8", qi.count); end
            end
            total++; if (qi.deq_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", qi.deq_valid); end
            total++; if ({qi.deq_pc, qi.deq_inst} !== sb[0] || qi.deq_order !== m_order) begin
                bad++; $display("FAIL wrap_head got=%h/%h/%0d exp=%h/%0d", qi.deq_pc, qi.deq_inst, qi.deq_order, sb[0], m_order);
            end
            tick();
            if (last_acc) npc = npc + 32'd4;
        end
        qi.enq_valid = 0;
        for (int k = 0; k < 2 * DEPTH && sb.size() != 0; k++) begin
            #1;
            total++; if ({qi.deq_pc, qi.deq_inst} !== sb[0] || qi.deq_order !== m_order) begin
                bad++; $display("FAIL drain_head got=%h/%0d exp=%h/%0d", qi.deq_pc, qi.deq_order, sb[0], m_order);
            end
            tick();
        end
        qi.deq_rdy = 0;
        #1;
        total++; if (qi.count !== '0 || qi.deq_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d/%b exp=0/0", qi.count, qi.deq_valid); end
    endtask

    task automatic test_single();
        qi.enq_valid = 1; qi.enq_pc = 32'h2000; qi.enq_inst = 32'h0050_0093; qi.deq_rdy = 1;
        #1;
        total++; if (qi.deq_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b exp=0", qi.deq_valid); end
        tick();
        qi.enq_valid = 0;
        #1;
        total++; if (qi.deq_valid !== 1'b1 || qi.deq_inst !== 32'h0050_0093) begin bad++; $display("FAIL single_visible got=%b/%h exp=1/00500093", qi.deq_valid, qi.deq_inst); end
        total++; if (qi.deq_order !== m_order) begin bad++; $display("FAIL single_order got=%0d exp=%0d", qi.deq_order, m_order); end
        tick();
        qi.deq_rdy = 0;
        #1;
        total++; if (qi.count !== '0 || qi.deq_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0d/%b exp=0/0", qi.count, qi.deq_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            qi.enq_valid = 1; qi.enq_pc = 32'(32'h3100 + 4 * i); qi.enq_inst = 32'(i); qi.deq_rdy = 0;
            tick();
        end
        qi.flush = 1; qi.flush_order = 64'h64;
        qi.enq_valid = 1; qi.enq_pc = 32'h3000; qi.enq_inst = 32'hDEAD_BEEF; qi.deq_rdy = 1;
        #1;
        total++; if (qi.enq_rdy !== 1'b0 || qi.deq_valid !== 1'b0) begin bad++; $display("FAIL flush_gate got=%b/%b exp=0/0", qi.enq_rdy, qi.deq_valid); end
        tick();
        qi.flush = 0; qi.enq_valid = 0; qi.deq_rdy = 0;
        #1;
        total++; if (qi.count !== '0 || qi.deq_valid !== 1'b0 || qi.enq_rdy !== 1'b1) begin
            bad++; $display("FAIL flush_after got=%0d/%b/%b exp=0/0/1", qi.count, qi.deq_valid, qi.enq_rdy);
        end
        qi.enq_valid = 1; qi.enq_pc = 32'h4000; qi.enq_inst = 32'h1111_2222;
        tick();
        qi.enq_valid = 0;
        #1;
        total++; if (qi.deq_valid !== 1'b1 || qi.deq_pc !== 32'h4000 || qi.deq_order !== 64'h64) begin
            bad++; $display("FAIL flush_resume got=%b/%h/%h exp=1/4000/64", qi.deq_valid, qi.deq_pc, qi.deq_order);
        end
        qi.deq_rdy = 1;
        tick();
        qi.deq_rdy = 0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            qi.enq_valid = 1; qi.enq_pc = 32'(32'h5100 + 4 * i); qi.enq_inst = 32'(i + 7); qi.deq_rdy = 0;
            tick();
        end
        qi.enq_valid = 0; qi.deq_rdy = 1;
        tick();
        qi.deq_rdy = 0;
        #2 rst = 0;
        #1;
        total++; if (qi.count !== '0 || qi.deq_valid !== 1'b0) begin bad++; $display("FAIL arst_imm got=%0d/%b exp=0/0", qi.count, qi.deq_valid); end
        total++; if (qi.deq_order !== 64'h0 || qi.deq_pc !== 32'h0) begin bad++; $display("FAIL arst_data got=%h/%h exp=0/0", qi.deq_order, qi.deq_pc); end
        sb.delete(); m_order = '0;
        @(negedge clk);
        rst = 1;
        qi.enq_valid = 1; qi.enq_pc = 32'h5000; qi.enq_inst = 32'h0000_0013;
        tick();
        qi.enq_valid = 0;
        #1;
        total++; if (qi.deq_valid !== 1'b1 || qi.deq_pc !== 32'h5000 || qi.deq_order !== 64'h0) begin
            bad++; $display("FAIL arst_resume got=%b/%h/%0d exp=1/5000/0", qi.deq_valid, qi.deq_pc, qi.deq_order);
        end
        qi.deq_rdy = 1;
        tick();
        qi.deq_rdy = 0;
    endtask

    task automatic test_random();
        bit          stall;
        bit          exp_dv;
        logic [31:0] ppc;
        logic [31:0] pinst;
        logic [63:0] pord;
        stall = 0; last_acc = 0; qi.enq_valid = 0;
        ppc = '0; pinst = '0; pord = '0;
        for (int c = 0; c < 10000; c++) begin
            if (!(qi.enq_valid && !last_acc)) begin
                qi.enq_valid = ($urandom_range(0, 99) < 60);
                qi.enq_pc = $urandom; qi.enq_inst = $urandom;
            end
            qi.deq_rdy = ($urandom_range(0, 99) < 50);
            qi.flush = (c == 100) || ($urandom_range(0, 499) == 0);
            qi.flush_order = (c < 5000) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            #1;
            exp_dv = (sb.size() != 0) && !qi.flush;
            total++; if (qi.enq_rdy !== ((sb.size() < DEPTH) && !qi.flush)) begin bad++; $display("FAIL rnd_enq_rdy c=%0d got=%b", c, qi.enq_rdy); end
            total++; if (qi.deq_valid !== exp_dv) begin bad++; $display("FAIL rnd_deq_valid c=%0d got=%b exp=%b", c, qi.deq_valid, exp_dv); end
            total++; if (qi.count !== CNT_W'(sb.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, qi.count, sb.size()); end
            if (exp_dv) begin
                total++; if ({qi.deq_pc, qi.deq_inst} !== sb[0] || qi.deq_order !== m_order) begin
                    bad++; $display("FAIL rnd_head c=%0d got=%h/%h/%h exp=%h/%h", c, qi.deq_pc, qi.deq_inst, qi.deq_order, sb[0], m_order);
                end
            end
            if (stall && !qi.flush) begin
                total++; if (qi.deq_pc !== ppc || qi.deq_inst !== pinst || qi.deq_order !== pord) begin
                    bad++; $display("FAIL rnd_stall_stable c=%0d got=%h/%h/%h exp=%h/%h/%h", c, qi.deq_pc, qi.deq_inst, qi.deq_order, ppc, pinst, pord);
                end
            end
            stall = exp_dv && !qi.deq_rdy;
            ppc = qi.deq_pc; pinst = qi.deq_inst; pord = qi.deq_order;
            tick();
        end
        qi.enq_valid = 0; qi.deq_rdy = 0; qi.flush = 1; qi.flush_order = '0;
        tick();
        qi.flush = 0;
        #1;
        total++; if (qi.count !== '0 || qi.deq_order !== 64'h0) begin bad++; $display("FAIL rnd_final got=%0d/%h exp=0/0", qi.count, qi.deq_order); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_single();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between fetch and the decoder in the out-of-order core. It buffers fetched {pc, inst} pairs in a circular FIFO, hands them to the decoder in program order with a valid/ready handshake, and tags each dequeued instruction with a 64-bit program-order number. A flush from the ROB empties the queue in one cycle and reloads the order counter so numbering resumes after the redirect.

## Interface
- DEPTH, 8, number of entries; power of two, >= 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- enq_valid  in  1  fetch presents an instruction
- enq_pc  in  32  PC of the presented instruction
- enq_inst  in  32  instruction word
- enq_rdy  out  1  queue accepts this cycle; enqueue occurs when enq_valid && enq_rdy
- deq_valid  out  1  head entry presented to the decoder
- deq_pc  out  32  PC of the head entry
- deq_inst  out  32  instruction word of the head entry
- deq_order  out  64  program-order tag of the head entry
- deq_rdy  in  1  decoder consumes; dequeue occurs when deq_valid && deq_rdy
- flush  in  1  redirect from ROB; empties the queue
- flush_order  in  64  order tag given to the first instruction dequeued after the flush
- count  out  $clog2(DEPTH)+1  current number of valid entries

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}; head and tail pointers of $clog2(DEPTH)+1 bits each (extra wrap bit).
- empty = (head == tail); full = index bits equal and wrap bits differ.
- count = tail - head, modulo 2^($clog2(DEPTH)+1).
- enq_rdy = !full && !flush; deq_valid = !empty && !flush. Both are combinational from registered state plus flush; neither depends on enq_valid or deq_rdy.
- Enqueue: write entry[tail index]; tail <= tail + 1, wrapping naturally.
- Dequeue: head <= head + 1; order counter <= order counter + 1.
- deq_pc/deq_inst = entry[head index]; deq_order = order counter. Outputs are don't-care while deq_valid = 0, but must not be X after reset (storage is reset to 0).
- Simultaneous enqueue and dequeue on a non-empty, non-full queue: both occur; count is unchanged.
- Enqueue to an empty queue: the entry is not bypassed; it becomes visible at deq the next cycle.
- When full, enq_rdy = 0 even if the decoder dequeues that same cycle. There is no same-cycle slot reuse.
- Flush (synchronous, highest priority): head <= 0, tail <= 0, order counter <= flush_order. Any enqueue or dequeue attempted in the flush cycle is ignored, which is guaranteed by the gated rdy/valid.
- Order counter arithmetic is 64-bit unsigned and wraps modulo 2^64.
- Reset (any time, including mid-operation): head = tail = 0, order counter = 0, all entries = 0. Resulting outputs: enq_rdy = 1 (when flush = 0), deq_valid = 0, count = 0, deq_pc = 0, deq_inst = 0, deq_order = 0.

## Timing
- Enqueue-to-deq_valid latency: 1 cycle.
- Dequeue throughput: 1 instruction/cycle when the queue is non-empty and deq_rdy is held high.
- Enqueue throughput: 1 instruction/cycle while not full.
- Flush takes effect at the next edge. The cycle after flush shows count = 0, deq_valid = 0, enq_rdy = 1.
- Handshakes follow valid/ready rules. The producer holds enq_* stable until accepted. The queue holds deq_* stable while deq_valid && !deq_rdy; only a flush or reset may withdraw deq_valid.
- No combinational path from enq_* to deq_*. Paths flush -> enq_rdy and flush -> deq_valid are combinational.

## Test plan
- Reset release, then enqueue pc=0x1000..0x101C (8 instrs, DEPTH=8) with deq_rdy=0 -> count reaches 8, enq_rdy drops after the 8th accept, deq_pc=0x1000, deq_order=0.
- Full queue with deq_rdy=1 and enq_valid=1 each cycle -> the first dequeue cycle has enq_rdy=0; from the next cycle count stays 7..8 and deq_order increments 0,1,2,… with PCs strictly in order through pointer wrap (>= 3*DEPTH instructions).
- Empty queue, single enqueue of inst=0x00500093 -> deq_valid rises exactly 1 cycle later with that inst; deq_rdy=1 returns count to 0 the following cycle.
- Queue holding 5 entries, flush=1 with flush_order=0x64, simultaneous enq_valid and deq_rdy -> next cycle count=0, deq_valid=0, no entry written; the next enqueued instruction dequeues with deq_order=0x64.
- rst driven low asynchronously mid-stream (between clock edges, queue holding 3 entries) -> immediately count=0, deq_valid=0, deq_order=0; after release the queue operates normally from order 0.
- Random valid/ready back-pressure over 10k cycles checked against a scoreboard -> no loss, duplication, or reordering; deq_* stable while stalled.
